// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD types, FSM states and counter sizing for bcd_serial_subtractor
package bcd_pkg;

   localparam int BCD_RADIX = 10;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Digit counter width: clog2(DIGITS), never narrower than one bit
   function automatic int cnt_width(input int digits);
      return (digits <= 2) ? 1 : $clog2(digits);
   endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// rtl/bcd_digit_sub.sv - combinational single BCD digit subtract with borrow and invalid-digit detect
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  bcd_digit_t a_d,
   input  bcd_digit_t b_d,
   input  logic       bi,
   output bcd_digit_t d,
   output logic       bo,
   output logic       inv
);

   logic [4:0] t;

   // 5-bit two's-complement difference; bit 4 is the sign for the full -16..15 range
   always_comb begin
      t   = {1'b0, a_d} - {1'b0, b_d} - {4'b0000, bi};
      bo  = t[4];
      d   = t[4] ? (t[3:0] + 4'(BCD_RADIX)) : t[3:0];
      inv = (a_d > 4'(BCD_RADIX - 1)) | (b_d > 4'(BCD_RADIX - 1));
   end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// rtl/bcd_serial_subtractor.sv - digit-serial packed-BCD subtractor, LSD first; BCD_SUB_DIGIT_CHECK_EN adds err flag
module bcd_serial_subtractor
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  bout,
   output logic                  err
);

   localparam int              CW   = cnt_width(DIGITS);
   localparam logic [CW-1:0]   LAST = CW'(DIGITS - 1);

   state_e                 state_q;
   logic [CW-1:0]          cnt_q;
   logic [4*DIGITS-1:0]    a_q;
   logic [4*DIGITS-1:0]    b_q;
   logic                   borrow_q;
   logic [4*DIGITS-1:0]    diff_q;
   logic [4*DIGITS-1:0]    diff_d;
   logic                   bout_q;
   logic                   busy_q;
   logic                   done_q;

   bcd_digit_t             a_dig;
   bcd_digit_t             b_dig;
   bcd_digit_t             sub_d;
   logic                   sub_bo;
   logic                   sub_inv;

   assign a_dig = bcd_digit_t'(a_q >> {cnt_q, 2'b00});
   assign b_dig = bcd_digit_t'(b_q >> {cnt_q, 2'b00});

   bcd_digit_sub u_digit_sub (
      .a_d (a_dig),
      .b_d (b_dig),
      .bi  (borrow_q),
      .d   (sub_d),
      .bo  (sub_bo),
      .inv (sub_inv)
   );

   always_comb begin
      diff_d = diff_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (cnt_q == CW'(i)) begin
            diff_d[4*i +: 4] = sub_d;
         end
      end
   end

`ifdef BCD_SUB_DIGIT_CHECK_EN
   logic flag_q;
   logic err_q;
`else
   logic unused_inv;
   assign unused_inv = sub_inv;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
         flag_q   <= 1'b0;
         err_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q      <= a;
                  b_q      <= b;
                  borrow_q <= bin;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= RUN;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                  flag_q   <= 1'b0;
`endif
               end
            end
            RUN: begin
               diff_q   <= diff_d;
               borrow_q <= sub_bo;
`ifdef BCD_SUB_DIGIT_CHECK_EN
               if (sub_inv) begin
                  flag_q <= 1'b1;
               end
`endif
               if (cnt_q == LAST) begin
                  bout_q  <= sub_bo;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= IDLE;
`ifdef BCD_SUB_DIGIT_CHECK_EN
                  // include the final digit's check, which the sticky flag has not seen yet
                  err_q   <= flag_q | sub_inv;
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign diff = diff_q;
   assign bout = bout_q;
`ifdef BCD_SUB_DIGIT_CHECK_EN
   assign err  = err_q;
`else
   assign err  = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// tb/tb_bcd_serial_subtractor.sv - directed table-driven bench for bcd_serial_subtractor (DIGITS=4)
module tb_bcd_serial_subtractor;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        bin;
   logic        busy;
   logic        done;
   logic [15:0] diff;
   logic        bout;
   logic        err;

   int checks;
   int errors;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] diff;
      logic        bout;
      logic        err;
   } vec_t;

   vec_t vecs [12];

   bcd_serial_subtractor #(.DIGITS(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .err   (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at the negedge following the start edge; returns on the negedge where done is seen
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy) busy_cnt++;
      end
   endtask

   task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                         output int lat, output int busy_cnt);
      @(negedge clk);
      a     = va;
      b     = vb;
      bin   = vbin;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, busy_cnt);
   endtask

   logic chk_en;
   int   lat;
   int   bcnt;
   int   done_cnt;
   logic [15:0] cap_diff;
   logic        cap_bout;

   initial begin
      checks = 0;
      errors = 0;
`ifdef BCD_SUB_DIGIT_CHECK_EN
      chk_en = 1'b1;
`else
      chk_en = 1'b0;
`endif
      vecs[0]  = '{16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0};
      vecs[1]  = '{16'h0017, 16'h0042, 1'b0, 16'h9975, 1'b1, 1'b0};
      vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 16'h9999, 1'b1, 1'b0};
      vecs[3]  = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
      vecs[4]  = '{16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0};
      vecs[5]  = '{16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0};
      vecs[6]  = '{16'h9999, 16'h0000, 1'b1, 16'h9998, 1'b0, 1'b0};
      vecs[7]  = '{16'h0000, 16'h9999, 1'b0, 16'h0001, 1'b1, 1'b0};
      vecs[8]  = '{16'h5000, 16'h4999, 1'b1, 16'h0000, 1'b0, 1'b0};
      vecs[9]  = '{16'h00A1, 16'h0001, 1'b0, 16'h00A0, 1'b0, chk_en};
      vecs[10] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[11] = '{16'hB000, 16'h0000, 1'b0, 16'hB000, 1'b0, chk_en};

      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_diff", diff, 0);
      check("reset_bout", bout, 0);
      check("reset_err",  err,  0);

      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].bin, lat, bcnt);
         check($sformatf("vec%0d_latency", i), lat, 4);
         check($sformatf("vec%0d_busy_cycles", i), bcnt, 4);
         check($sformatf("vec%0d_diff", i), diff, vecs[i].diff);
         check($sformatf("vec%0d_bout", i), bout, vecs[i].bout);
         check($sformatf("vec%0d_err", i), err, vecs[i].err);
      end

      // Operand change and start held mid-run must not disturb the latched operation
      @(negedge clk);
      a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 16'h9999; b = 16'h1234; bin = 1'b1;
      @(negedge clk);
      @(negedge clk);
      start = 1'b0;
      done_cnt = 0;
      cap_diff = '0;
      cap_bout = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            cap_diff = diff;
            cap_bout = bout;
         end
      end
      check("midrun_done_pulses", done_cnt, 1);
      check("midrun_diff", cap_diff, 16'h0025);
      check("midrun_bout", cap_bout, 0);

      // Start during the done cycle begins the next operation immediately
      run_op(16'h0042, 16'h0017, 1'b0, lat, bcnt);
      check("b2b_first_done", done, 1);
      a = 16'h0017; b = 16'h0042; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy_next", busy, 1);
      check("b2b_done_cleared", done, 0);
      check("b2b_diff_held", diff, 16'h0025);
      wait_done(lat, bcnt);
      check("b2b_latency", lat, 4);
      check("b2b_diff", diff, 16'h9975);
      check("b2b_bout", bout, 1);

      // Asynchronous reset with digit 2 pending aborts with no done
      @(negedge clk);
      a = 16'h9234; b = 16'h0567; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_diff", diff, 0);
      check("abort_bout", bout, 0);
      check("abort_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      done_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done) done_cnt++;
      end
      check("abort_no_done", done_cnt, 0);
      check("abort_idle_busy", busy, 0);
      run_op(16'h1000, 16'h0001, 1'b0, lat, bcnt);
      check("post_reset_latency", lat, 4);
      check("post_reset_diff", diff, 16'h0999);
      check("post_reset_bout", bout, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
